// File: rtl/uart_cmd_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART command parser: state
//               encoding, default command bytes and frame lengths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default command bytes ('R' and 'W').
  localparam logic [7:0] c_CMD_READ  = 8'h52;
  localparam logic [7:0] c_CMD_WRITE = 8'h57;

  // Frame lengths in bytes, including the command and checksum bytes.
  localparam int c_READ_LEN   = 3;
  localparam int c_WRITE_LEN  = 7;
  // Payload bytes in a write frame (everything but CMD, ADDR and CHK).
  localparam int c_DATA_BYTES = c_WRITE_LEN - 3;

  // Parser state encoding.
  localparam logic [2:0] c_ST_CMD   = 3'd0;
  localparam logic [2:0] c_ST_ADDR  = 3'd1;
  localparam logic [2:0] c_ST_DATA  = 3'd2;
  localparam logic [2:0] c_ST_CHK   = 3'd3;
  localparam logic [2:0] c_ST_ISSUE = 3'd4;
  localparam logic [2:0] c_ST_WAIT  = 3'd5;

  typedef enum logic [2:0] {
    S_CMD   = c_ST_CMD,
    S_ADDR  = c_ST_ADDR,
    S_DATA  = c_ST_DATA,
    S_CHK   = c_ST_CHK,
    S_ISSUE = c_ST_ISSUE,
    S_WAIT  = c_ST_WAIT
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser_if
// Description : Bundle between the UART receiver / register block and the
//               command parser.
//   master : parser side  - consumes RX_* and DONE, drives the command
//   slave  : environment  - drives RX_* and DONE, consumes the command
//   RX_DATA[7:0], RX_VALID, RX_ERR : received byte and qualifiers
//   DONE                           : completion pulse from register block
//   START, STATE_R/W/FAIL          : command strobe and kind
//   ADDR[7:0], DATA_OUT[31:0]      : command address / write data
//   BUSY, OVERRUN                  : status
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_parser_if;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_ERR;
  logic        DONE;
  logic        START;
  logic        STATE_R;
  logic        STATE_W;
  logic        STATE_FAIL;
  logic [7:0]  ADDR;
  logic [31:0] DATA_OUT;
  logic        BUSY;
  logic        OVERRUN;

  modport master (
    input  RX_DATA, RX_VALID, RX_ERR, DONE,
    output START, STATE_R, STATE_W, STATE_FAIL, ADDR, DATA_OUT, BUSY, OVERRUN
  );

  modport slave (
    output RX_DATA, RX_VALID, RX_ERR, DONE,
    input  START, STATE_R, STATE_W, STATE_FAIL, ADDR, DATA_OUT, BUSY, OVERRUN
  );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_parser_byte_timeout.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_timeout
// Description : Inter-byte timeout counter. Clears on i_clr, otherwise counts
//               while i_en, saturating at TIMEOUT_CYCLES-1 (never wraps).
//   clk, rst   : clock, synchronous active-high reset
//   i_clr      : clear counter (has priority over i_en)
//   i_en       : count enable
//   o_expired  : counter has reached TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_expired
);

  localparam int              c_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_W-1:0]  c_LAST = c_W'(TIMEOUT_CYCLES - 1);

  logic [c_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_LAST)) begin
      r_cnt <= r_cnt + c_W'(1);
    end
  end

  assign o_expired = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser
// Description : Assembles UART bytes into READ (CMD,ADDR,CHK) or WRITE
//               (CMD,ADDR,D3..D0,CHK) frames, checks the XOR checksum and the
//               inter-byte timeout, then issues one command (START pulse) and
//               holds it until the register block returns DONE.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : uart_cmd_parser_if.master (RX byte stream in, command out)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] CMD_READ       = c_CMD_READ,
  parameter logic [7:0] CMD_WRITE      = c_CMD_WRITE
) (
  input  wire logic           CLK,
  input  wire logic           RST,
  uart_cmd_parser_if.master   bus
);

  localparam logic [1:0] c_LAST_DATA = 2'(c_DATA_BYTES - 1);

  state_t      r_state;
  logic        r_is_write;
  logic [7:0]  r_chk;
  logic [1:0]  r_cnt;
  logic        r_start;
  logic        r_rd;
  logic        r_wr;
  logic        r_fail;
  logic [7:0]  r_addr;
  logic [31:0] r_data;
  logic        r_busy;
  logic        r_overrun;

  logic w_in_frame;
  logic w_tmo_clr;
  logic w_tmo_exp;
  logic w_bad_cmd;
  logic w_fail;
  logic w_pass;

  // The timeout only runs between the bytes of a frame; holding it clear
  // outside those states means it starts from zero on entry to S_ADDR.
  assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_CHK);
  assign w_tmo_clr  = bus.RX_VALID || !w_in_frame;

  uart_byte_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (CLK),
    .rst       (RST),
    .i_clr     (w_tmo_clr),
    .i_en      (w_in_frame),
    .o_expired (w_tmo_exp)
  );

  assign w_bad_cmd = (bus.RX_DATA != CMD_READ) && (bus.RX_DATA != CMD_WRITE);

  // Every route into a failed command. A byte arriving in the expiry cycle
  // takes precedence over the timeout.
  assign w_fail = ((r_state == S_CMD) && bus.RX_VALID && (bus.RX_ERR || w_bad_cmd))
               || (w_in_frame && bus.RX_VALID && bus.RX_ERR)
               || ((r_state == S_CHK) && bus.RX_VALID && (bus.RX_DATA != r_chk))
               || (w_in_frame && !bus.RX_VALID && w_tmo_exp);

  assign w_pass = (r_state == S_CHK) && bus.RX_VALID && !bus.RX_ERR && (bus.RX_DATA == r_chk);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_CMD;
      r_is_write <= 1'b0;
      r_chk      <= '0;
      r_cnt      <= '0;
      r_start    <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_fail     <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      // Bytes are never queued while a command is outstanding.
      r_overrun <= bus.RX_VALID && ((r_state == S_ISSUE) || (r_state == S_WAIT));

      if (w_fail) begin
        r_state <= S_ISSUE;
        r_start <= 1'b1;
        r_busy  <= 1'b1;
        r_fail  <= 1'b1;
        r_rd    <= 1'b0;
        r_wr    <= 1'b0;
        r_addr  <= '0;
        r_data  <= '0;
      end else begin
        case (r_state)
          S_CMD: begin
            // Only a valid command byte reaches here; bad ones take w_fail.
            if (bus.RX_VALID) begin
              r_is_write <= (bus.RX_DATA == CMD_WRITE);
              r_chk      <= bus.RX_DATA;
              r_state    <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (bus.RX_VALID) begin
              r_addr  <= bus.RX_DATA;
              r_chk   <= r_chk ^ bus.RX_DATA;
              r_cnt   <= '0;
              r_state <= r_is_write ? S_DATA : S_CHK;
            end
          end
          S_DATA: begin
            if (bus.RX_VALID) begin
              r_data <= {r_data[23:0], bus.RX_DATA};
              r_chk  <= r_chk ^ bus.RX_DATA;
              r_cnt  <= r_cnt + 2'd1;
              if (r_cnt == c_LAST_DATA) begin
                r_state <= S_CHK;
              end
            end
          end
          S_CHK: begin
            if (w_pass) begin
              r_state <= S_ISSUE;
              r_start <= 1'b1;
              r_busy  <= 1'b1;
              r_rd    <= !r_is_write;
              r_wr    <= r_is_write;
              if (!r_is_write) begin
                r_data <= '0;
              end
            end
          end
          S_ISSUE: begin
            r_start <= 1'b0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (bus.DONE) begin
              r_rd    <= 1'b0;
              r_wr    <= 1'b0;
              r_fail  <= 1'b0;
              r_busy  <= 1'b0;
              r_addr  <= '0;
              r_data  <= '0;
              r_chk   <= '0;
              r_state <= S_CMD;
            end
          end
          default: begin
            r_state <= S_CMD;
          end
        endcase
      end
    end
  end

  assign bus.START      = r_start;
  assign bus.STATE_R    = r_rd;
  assign bus.STATE_W    = r_wr;
  assign bus.STATE_FAIL = r_fail;
  assign bus.ADDR       = r_addr;
  assign bus.DATA_OUT   = r_data;
  assign bus.BUSY       = r_busy;
  assign bus.OVERRUN    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_parser
// Description : Self-checking bench for uart_cmd_parser. A frame-level
//               reference model predicts the command each byte sequence
//               should produce; a tiny register-block model answers DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

  localparam int c_TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .TIMEOUT_CYCLES (c_TMO)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  // Current frame under test.
  logic [7:0] fb [7];
  bit         fe [7];

  // Reference-model expectation: kind 0=fail 1=read 2=write.
  int          exp_kind;
  int          exp_used;
  logic [7:0]  exp_addr;
  logic [31:0] exp_data;

  // Register-block memories: one fed from the model, one from the DUT.
  logic [31:0] mem_exp [256];
  logic [31:0] mem_dut [256];

  always @(posedge clk) begin
    if (bus.START === 1'b1) start_cnt = start_cnt + 1;
  end

  function automatic void load(input logic [55:0] v, input int n);
    for (int i = 0; i < 7; i++) begin
      fe[i] = 1'b0;
      if (i < n) fb[i] = v[8*(n-1-i) +: 8];
      else       fb[i] = 8'h00;
    end
  endfunction

  function automatic void fix_chk(input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n - 1; i++) x = x ^ fb[i];
    fb[n-1] = x;
  endfunction

  // Frame semantics: how many bytes the parser consumes and what it issues.
  function automatic void ref_model();
    int         len;
    logic [7:0] x;
    exp_kind = 0;
    exp_addr = 8'h00;
    exp_data = 32'h0;
    exp_used = 1;
    if (fe[0] || (fb[0] != 8'h52 && fb[0] != 8'h57)) return;
    len = (fb[0] == 8'h57) ? 7 : 3;
    x = 8'h00;
    for (int i = 0; i < len; i++) begin
      exp_used = i + 1;
      if (fe[i]) return;
      if (i == len - 1) begin
        if (fb[i] == x) begin
          exp_kind = (len == 7) ? 2 : 1;
          exp_addr = fb[1];
          if (len == 7) exp_data = {fb[2], fb[3], fb[4], fb[5]};
        end
        return;
      end
      x = x ^ fb[i];
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit e);
    bus.RX_DATA  = b;
    bus.RX_VALID = 1'b1;
    bus.RX_ERR   = e;
    @(negedge clk);
    bus.RX_VALID = 1'b0;
    bus.RX_ERR   = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    ref_model();
    for (int i = 0; i < exp_used; i++) begin
      if (i > 0 && max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      send_byte(fb[i], fe[i]);
    end
  endtask

  // Called on the cycle START is due: checks the issue, the hold in WAIT,
  // register-block readback, and the DONE handshake.
  task automatic check_issue(input string name);
    logic [4:0] want;
    int         s0;
    s0   = start_cnt;
    want = {1'b1, 1'b1, exp_kind == 1, exp_kind == 2, exp_kind == 0};
    checks++;
    if ({bus.START, bus.BUSY, bus.STATE_R, bus.STATE_W, bus.STATE_FAIL} !== want) begin
      errors++;
      $display("FAIL %s issue start/busy/r/w/fail got %b want %b", name,
               {bus.START, bus.BUSY, bus.STATE_R, bus.STATE_W, bus.STATE_FAIL}, want);
    end
    checks++;
    if ({bus.ADDR, bus.DATA_OUT} !== {exp_addr, exp_data}) begin
      errors++;
      $display("FAIL %s issue addr/data got %h/%h want %h/%h", name, bus.ADDR, bus.DATA_OUT, exp_addr, exp_data);
    end
    repeat ($urandom_range(3, 0) + 1) @(negedge clk);
    want[4] = 1'b0;
    checks++;
    if ({bus.START, bus.BUSY, bus.STATE_R, bus.STATE_W, bus.STATE_FAIL, bus.ADDR, bus.DATA_OUT}
        !== {want, exp_addr, exp_data}) begin
      errors++;
      $display("FAIL %s wait hold got %b/%h/%h want %b/%h/%h", name,
               {bus.START, bus.BUSY, bus.STATE_R, bus.STATE_W, bus.STATE_FAIL}, bus.ADDR, bus.DATA_OUT,
               want, exp_addr, exp_data);
    end
    if (exp_kind == 2) begin
      mem_exp[exp_addr] = exp_data;
      mem_dut[bus.ADDR] = bus.DATA_OUT;
    end else if (exp_kind == 1) begin
      checks++;
      if (mem_dut[bus.ADDR] !== mem_exp[exp_addr]) begin
        errors++;
        $display("FAIL %s readback got %h want %h", name, mem_dut[bus.ADDR], mem_exp[exp_addr]);
      end
    end
    bus.DONE = 1'b1;
    @(negedge clk);
    bus.DONE = 1'b0;
    checks++;
    if ({bus.START, bus.BUSY, bus.STATE_R, bus.STATE_W, bus.STATE_FAIL, bus.ADDR, bus.DATA_OUT} !== 45'd0) begin
      errors++;
      $display("FAIL %s after done got %b/%h/%h want all zero", name,
               {bus.START, bus.BUSY, bus.STATE_R, bus.STATE_W, bus.STATE_FAIL}, bus.ADDR, bus.DATA_OUT);
    end
    checks++;
    if (start_cnt !== s0 + 1) begin
      errors++;
      $display("FAIL %s start pulses got %0d want 1", name, start_cnt - s0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.START, bus.BUSY, bus.STATE_R, bus.STATE_W, bus.STATE_FAIL, bus.OVERRUN, bus.ADDR, bus.DATA_OUT} !== 46'd0) begin
      errors++;
      $display("FAIL reset outputs got %h want 0",
               {bus.START, bus.BUSY, bus.STATE_R, bus.STATE_W, bus.STATE_FAIL, bus.OVERRUN, bus.ADDR, bus.DATA_OUT});
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    load(56'h5710DEADBEEF65, 7);
    send_frame(2);
    check_issue("write");
  endtask

  task automatic test_read();
    load(56'h521042, 3);
    send_frame(2);
    check_issue("read");
  endtask

  task automatic test_bad_chk();
    load(56'h5710DEADBEEF66, 7);
    send_frame(1);
    check_issue("bad_chk");
    load(56'h521042, 3);
    send_frame(0);
    check_issue("after_bad_chk");
  endtask

  task automatic test_invalid();
    load(56'h41, 1);
    send_frame(0);
    check_issue("invalid_cmd");
    load(56'h521042, 3);
    fe[1] = 1'b1;
    send_frame(0);
    check_issue("rx_err_addr");
  endtask

  task automatic test_timeout();
    int  first;
    bit  seen;
    load(56'h5710DEADBEEF65, 7);
    send_byte(8'h57, 1'b0);
    send_byte(8'h10, 1'b0);
    first = 0;
    for (int k = 1; k <= c_TMO + 4 && first == 0; k++) begin
      @(negedge clk);
      if (bus.START === 1'b1) first = k;
    end
    checks++;
    if (first != c_TMO) begin
      errors++;
      $display("FAIL timeout latency got %0d want %0d", first, c_TMO);
    end
    if (first != 0) begin
      exp_kind = 0; exp_addr = 8'h00; exp_data = 32'h0;
      check_issue("timeout");
    end
    // Byte landing exactly in the expiry cycle keeps the frame alive.
    send_byte(8'h57, 1'b0);
    send_byte(8'h10, 1'b0);
    seen = 1'b0;
    repeat (c_TMO - 1) begin
      @(negedge clk);
      if (bus.START !== 1'b0) seen = 1'b1;
    end
    send_byte(8'hDE, 1'b0);
    checks++;
    if (seen || bus.START !== 1'b0) begin
      errors++;
      $display("FAIL timeout_edge early start got %b want 0", 1'b1);
    end
    for (int i = 3; i < 7; i++) send_byte(fb[i], 1'b0);
    ref_model();
    check_issue("timeout_edge");
  endtask

  task automatic test_done_ignored();
    bus.DONE = 1'b1;
    @(negedge clk);
    bus.DONE = 1'b0;
    load(56'h57200102030400, 7);
    fix_chk(7);
    ref_model();
    send_byte(fb[0], 1'b0);
    send_byte(fb[1], 1'b0);
    bus.DONE = 1'b1;
    @(negedge clk);
    bus.DONE = 1'b0;
    for (int i = 2; i < 7; i++) send_byte(fb[i], 1'b0);
    check_issue("done_ignored");
  endtask

  task automatic test_overrun();
    load(56'h521042, 3);
    ref_model();
    for (int i = 0; i < 3; i++) send_byte(fb[i], 1'b0);
    send_byte(8'h57, 1'b0);
    checks++;
    if ({bus.OVERRUN, bus.BUSY, bus.STATE_R, bus.START} !== 4'b1110) begin
      errors++;
      $display("FAIL overrun pulse ovr/busy/r/start got %b want 1110", {bus.OVERRUN, bus.BUSY, bus.STATE_R, bus.START});
    end
    @(negedge clk);
    checks++;
    if (bus.OVERRUN !== 1'b0) begin
      errors++;
      $display("FAIL overrun width got %b want 0", bus.OVERRUN);
    end
    // Byte coinciding with DONE is also dropped.
    bus.DONE = 1'b1;
    send_byte(8'h52, 1'b0);
    bus.DONE = 1'b0;
    checks++;
    if ({bus.OVERRUN, bus.BUSY, bus.STATE_R} !== 3'b100) begin
      errors++;
      $display("FAIL overrun_done ovr/busy/r got %b want 100", {bus.OVERRUN, bus.BUSY, bus.STATE_R});
    end
    load(56'h5710DEADBEEF65, 7);
    send_frame(0);
    check_issue("after_overrun");
  endtask

  task automatic test_reset_mid();
    int s0;
    send_byte(8'h57, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'hDE, 1'b0);
    s0  = start_cnt;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.START, bus.BUSY, bus.STATE_R, bus.STATE_W, bus.STATE_FAIL, bus.OVERRUN, bus.ADDR, bus.DATA_OUT} !== 46'd0) begin
      errors++;
      $display("FAIL reset_mid outputs got %h want 0",
               {bus.START, bus.BUSY, bus.STATE_R, bus.STATE_W, bus.STATE_FAIL, bus.OVERRUN, bus.ADDR, bus.DATA_OUT});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt !== s0) begin
      errors++;
      $display("FAIL reset_mid spurious start got %0d want 0", start_cnt - s0);
    end
    load(56'h521042, 3);
    send_frame(1);
    check_issue("reset_mid_read");
  endtask

  task automatic test_random();
    int len;
    for (int n = 0; n < 40; n++) begin
      len = 3;
      case ($urandom_range(9, 0))
        0: begin
          fb[0] = 8'($urandom);
          while (fb[0] == 8'h52 || fb[0] == 8'h57) fb[0] = 8'($urandom);
        end
        1, 2, 3, 4: fb[0] = 8'h52;
        default: begin fb[0] = 8'h57; len = 7; end
      endcase
      fb[1] = 8'($urandom_range(7, 0));
      for (int i = 2; i < 7; i++) fb[i] = 8'($urandom);
      for (int i = 0; i < 7; i++) fe[i] = 1'b0;
      fix_chk(len);
      if ($urandom_range(3, 0) == 0) fb[len-1] = fb[len-1] ^ (8'h01 << $urandom_range(7, 0));
      if ($urandom_range(7, 0) == 0) fe[$urandom_range(len - 1, 0)] = 1'b1;
      send_frame(3);
      check_issue("random");
    end
  endtask

  initial begin
    bus.RX_DATA  = 8'h00;
    bus.RX_VALID = 1'b0;
    bus.RX_ERR   = 1'b0;
    bus.DONE     = 1'b0;
    rst          = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem_exp[i] = 32'h0;
      mem_dut[i] = 32'h0;
    end
    test_reset();
    test_write();
    test_read();
    test_bad_chk();
    test_invalid();
    test_timeout();
    test_done_ignored();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
